fwd_stall_unit: RTL and testbench
=================================

Name: fwd_stall_unit

Overview:
- Parametrised successor to the per-operand bypass selectors: one block resolves forwarding for NSRC decode-stage source operands against NSTAGES downstream producer stages.
- Keeps its own pipelined scoreboard of destination register, write enable and time-to-ready (tnew) per stage.
- Generates load-use and multiply/divide stalls, with bubble insertion into E.
- Sits beside the decode stage; drives the D-stage operand muxes and the D/E pipeline-register enables.

Parameters:
- NSTAGES, 3, producer stages after D (1=E, 2=M, 3=W, ...); range 2..7
- NSRC, 2, number of D-stage source operands
- TW, 2, width of tnew/tuse fields
- MD_LAT, 5, multiply/divide busy cycles after start; must be ≥1
- SELW, $clog2(NSTAGES+1), width of each forward select

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- src_addr_d  in  NSRC*5  source register numbers; operand i at [5i+4:5i]
- src_en_d  in  NSRC  operand i is actually read
- src_tuse_d  in  NSRC*TW  cycles from now until operand i is consumed
- dst_addr_d  in  5  destination register of the D instruction
- dst_wen_d  in  1  D instruction writes the register file
- dst_tnew_d  in  TW  cycles after entering E until the result is forwardable
- md_use_d  in  1  D instruction needs the multiply/divide unit or its results
- md_start_e  in  1  instruction in E starts a multiply/divide this cycle
- flush_e  in  1  kill the instruction entering E
- stall_d  out  1  hold PC and the D register
- bubble_e  out  1  load a bubble into E (stall_d | flush_e)
- fwd_sel  out  NSRC*SELW  per operand: 0 = register file, k = stage k
- md_busy  out  1  multiply/divide counter nonzero

Behaviour:
- Scoreboard: entry[k] for k=1..NSTAGES = {valid, addr, tnew}. All fields are registers.
- Every cycle, for k≥2: entry[k] <= entry[k-1] with tnew = sat0(tnew-1). Downstream stages never stall.
- entry[1] update:
  - bubble_e=1: entry[1].valid <= 0.
  - Otherwise: entry[1] <= {dst_wen_d && dst_addr_d!=0, dst_addr_d, dst_tnew_d}.
- Entry leaving stage NSTAGES is dropped. The register file is not write-through, so stage NSTAGES is a legal forward source.
- Match for operand i at stage k: src_en_d[i] && entry[k].valid && entry[k].addr==src_addr_d[i]. Register 0 never matches.
- Youngest match wins: the lowest k matching.
- Forwarding, if the youngest match has tnew==0: fwd_sel[i]=k.
- Otherwise fwd_sel[i]=0. This includes the no-match case and the not-yet-ready case; in the not-ready case the stall or a later stage re-resolves the operand.
- Data hazard, operand i: the youngest match has tnew > src_tuse_d[i]. Older matches are ignored.
- MD hazard: md_use_d && (md_busy || md_start_e).
- stall_d = OR over all data hazards, OR MD hazard. Combinational from the registers and the D inputs.
- During stall_d the D inputs are held by the pipeline; the block makes no other assumption about them.
- MD counter:
  - md_start_e=1 loads MD_LAT, even if the counter is already busy (restart).
  - Otherwise the counter decrements to 0 and saturates.
  - md_busy = (count != 0).
- md_start_e and flush_e in the same cycle: md_start_e belongs to the E instruction, so it still loads the counter.
- Reset: all entry.valid=0, counter=0. Hence stall_d=0, bubble_e=flush_e, fwd_sel=0 and md_busy=0 in the first cycle after reset.
- Reset asserted mid-stall: the next cycle the stall clears unless MD or D inputs re-create it from the empty scoreboard, which is impossible.
- Latency: forwarding and stall outputs are combinational. Scoreboard and counter update on the clock edge.

Test Plan:
1. ALU back-to-back:
   - Stimulus: add $8 (dst_tnew_d=1), then next cycle D reads $8 with tuse=0.
   - Cycle 1: stall_d=1, bubble_e=1.
   - Cycle 2: producer in M with tnew=0, so fwd_sel=2 and stall_d=0.
2. Load-use:
   - Stimulus: lw $9 with tnew=2, followed by a D read of $9 with tuse=1.
   - Cycle 1: stall 1 cycle (tnew 2 > tuse 1).
   - Cycle 2: no stall. fwd_sel=0 and tnew=1 ≤ 1, so no stall while the operand is re-resolved downstream.
3. Youngest wins:
   - Stimulus: $5 written by stage-2 entry (tnew=0) and by stage-3 entry (tnew=0).
   - Response: fwd_sel=2.
   - Variant, stage-1 entry for $5 with tnew=0: fwd_sel=1.
4. Register zero and disabled operand:
   - Stimulus: dst_addr_d=0 with wen=1, then read $0.
   - Response: fwd_sel=0, no stall. Same for src_en_d=0 on a matching address.
5. MD busy with MD_LAT=5:
   - Stimulus: md_start_e=1 at cycle t, md_use_d=1 from t.
   - Response: stall_d=1 for cycles t..t+5. md_busy falls after 5 decrements; stall_d=0 at t+6.
   - Restart: a second start at t+2 extends busy to t+7.
6. Flush and reset:
   - flush_e with a valid writer in D: no entry is recorded; the next reader gets fwd_sel=0 and no stall.
   - reset during a load-use stall: next cycle stall_d=0 and all fwd_sel=0.

Source files
------------

// File: rtl/fwd_stall_unit.sv
// Forwarding and stall resolution for the decode stage.
//
// Tracks, for each of NSTAGES producer stages downstream of D, which
// register the instruction there will write and how many cycles remain
// until its result can be forwarded (tnew). For every D-stage source
// operand it selects the youngest matching producer as the bypass source
// and raises stall_d when that producer cannot deliver in time. A
// multiply/divide busy counter adds a structural stall for instructions
// that use the MD unit.
//
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   src_addr_d   NSRC packed 5-bit source register numbers
//   src_en_d     per-operand "actually read" flags
//   src_tuse_d   per-operand cycles until the value is consumed
//   dst_addr_d   destination register of the D instruction
//   dst_wen_d    D instruction writes the register file
//   dst_tnew_d   cycles after entering E until its result is forwardable
//   md_use_d     D instruction needs the MD unit or its results
//   md_start_e   E instruction starts a multiply/divide this cycle
//   flush_e      kill the instruction entering E
//   stall_d      hold PC and the D register
//   bubble_e     load a bubble into E
//   fwd_sel      per operand: 0 = register file, k = stage k
//   md_busy      MD counter is nonzero
module fwd_stall_unit #(
  parameter int unsigned NSTAGES = 3,
  parameter int unsigned NSRC    = 2,
  parameter int unsigned TW      = 2,
  parameter int unsigned MD_LAT  = 5,
  parameter int unsigned SELW    = $clog2(NSTAGES + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NSRC*5-1:0]    src_addr_d,
  input  logic [NSRC-1:0]      src_en_d,
  input  logic [NSRC*TW-1:0]   src_tuse_d,
  input  logic [4:0]           dst_addr_d,
  input  logic                 dst_wen_d,
  input  logic [TW-1:0]        dst_tnew_d,
  input  logic                 md_use_d,
  input  logic                 md_start_e,
  input  logic                 flush_e,
  output logic                 stall_d,
  output logic                 bubble_e,
  output logic [NSRC*SELW-1:0] fwd_sel,
  output logic                 md_busy
);

  localparam int unsigned CW = $clog2(MD_LAT + 1);

  // Scoreboard: one entry per producer stage, index 1 = E.
  logic          valid_q [1:NSTAGES];
  logic [4:0]    addr_q  [1:NSTAGES];
  logic [TW-1:0] tnew_q  [1:NSTAGES];
  logic          valid_d [1:NSTAGES];
  logic [4:0]    addr_d  [1:NSTAGES];
  logic [TW-1:0] tnew_d  [1:NSTAGES];

  logic [CW-1:0] md_cnt_q, md_cnt_d;

  // Per-operand youngest-match results.
  logic            hit_c  [NSRC];
  logic [SELW-1:0] hitk_c [NSRC];
  logic [TW-1:0]   hitt_c [NSRC];
  logic [NSRC-1:0] data_haz;
  logic            md_haz;

  assign md_busy  = (md_cnt_q != '0);
  assign md_haz   = md_use_d && (md_busy || md_start_e);
  assign stall_d  = (|data_haz) || md_haz;
  assign bubble_e = stall_d || flush_e;

  // Youngest match: scan from the oldest stage down so the lowest k
  // that matches is the one left standing.
  always_comb begin
    fwd_sel  = '0;
    data_haz = '0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      hit_c[i]  = 1'b0;
      hitk_c[i] = '0;
      hitt_c[i] = '0;
      for (int unsigned k = NSTAGES; k >= 1; k--) begin
        if (src_en_d[i] && valid_q[k] && (addr_q[k] == src_addr_d[5*i +: 5])) begin
          hit_c[i]  = 1'b1;
          hitk_c[i] = SELW'(k);
          hitt_c[i] = tnew_q[k];
        end
      end
      if (hit_c[i] && (hitt_c[i] == '0))
        fwd_sel[SELW*i +: SELW] = hitk_c[i];
      data_haz[i] = hit_c[i] && (hitt_c[i] > src_tuse_d[TW*i +: TW]);
    end
  end

  // Scoreboard next state: E takes the D instruction or a bubble;
  // later stages shift unconditionally with tnew counting down to 0.
  always_comb begin
    valid_d[1] = dst_wen_d && (dst_addr_d != 5'd0) && !bubble_e;
    addr_d[1]  = dst_addr_d;
    tnew_d[1]  = dst_tnew_d;
    for (int unsigned k = 2; k <= NSTAGES; k++) begin
      valid_d[k] = valid_q[k-1];
      addr_d[k]  = addr_q[k-1];
      tnew_d[k]  = (tnew_q[k-1] == '0) ? '0 : tnew_q[k-1] - 1'b1;
    end
  end

  // A start always reloads, including while already busy.
  always_comb begin
    if (md_start_e)
      md_cnt_d = CW'(MD_LAT);
    else if (md_cnt_q != '0)
      md_cnt_d = md_cnt_q - 1'b1;
    else
      md_cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned k = 1; k <= NSTAGES; k++) begin
        valid_q[k] <= 1'b0;
        addr_q[k]  <= '0;
        tnew_q[k]  <= '0;
      end
      md_cnt_q <= '0;
    end else begin
      for (int unsigned k = 1; k <= NSTAGES; k++) begin
        valid_q[k] <= valid_d[k];
        addr_q[k]  <= addr_d[k];
        tnew_q[k]  <= tnew_d[k];
      end
      md_cnt_q <= md_cnt_d;
    end
  end

endmodule

// File: tb/tb_fwd_stall_unit.sv
module tb_fwd_stall_unit;

  localparam int unsigned NSTAGES = 3;
  localparam int unsigned NSRC    = 2;
  localparam int unsigned TW      = 2;
  localparam int unsigned MD_LAT  = 5;
  localparam int unsigned SELW    = 2;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NSRC*5-1:0]    src_addr_d;
  logic [NSRC-1:0]      src_en_d;
  logic [NSRC*TW-1:0]   src_tuse_d;
  logic [4:0]           dst_addr_d;
  logic                 dst_wen_d;
  logic [TW-1:0]        dst_tnew_d;
  logic                 md_use_d;
  logic                 md_start_e;
  logic                 flush_e;
  logic                 stall_d;
  logic                 bubble_e;
  logic [NSRC*SELW-1:0] fwd_sel;
  logic                 md_busy;

  fwd_stall_unit #(
    .NSTAGES(NSTAGES), .NSRC(NSRC), .TW(TW), .MD_LAT(MD_LAT), .SELW(SELW)
  ) dut (
    .clk(clk), .reset(reset),
    .src_addr_d(src_addr_d), .src_en_d(src_en_d), .src_tuse_d(src_tuse_d),
    .dst_addr_d(dst_addr_d), .dst_wen_d(dst_wen_d), .dst_tnew_d(dst_tnew_d),
    .md_use_d(md_use_d), .md_start_e(md_start_e), .flush_e(flush_e),
    .stall_d(stall_d), .bubble_e(bubble_e), .fwd_sel(fwd_sel), .md_busy(md_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string    name;
    logic     stall;
    logic     bubble;
    logic [3:0] fwd;
    logic     busy;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Monitor: outputs are combinational, so sample on the falling edge
  // of any cycle for which the stimulus queued an expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (stall_d !== e.stall) begin
        errors++;
        $display("FAIL %s stall_d: got %b expected %b", e.name, stall_d, e.stall);
      end
      checks++;
      if (bubble_e !== e.bubble) begin
        errors++;
        $display("FAIL %s bubble_e: got %b expected %b", e.name, bubble_e, e.bubble);
      end
      checks++;
      if (fwd_sel !== e.fwd) begin
        errors++;
        $display("FAIL %s fwd_sel: got %b expected %b", e.name, fwd_sel, e.fwd);
      end
      checks++;
      if (md_busy !== e.busy) begin
        errors++;
        $display("FAIL %s md_busy: got %b expected %b", e.name, md_busy, e.busy);
      end
    end
  end

  task automatic idle_inputs();
    src_addr_d = '0; src_en_d = '0; src_tuse_d = '0;
    dst_addr_d = '0; dst_wen_d = 1'b0; dst_tnew_d = '0;
    md_use_d = 1'b0; md_start_e = 1'b0; flush_e = 1'b0;
  endtask

  // One D-stage cycle: wait past the edge, drive, optionally queue expectation.
  // a0/a1: source regs, en: enables, t0/t1: tuse, dst/wen/tnew: writer.
  task automatic step(input logic [4:0] a0, input logic [4:0] a1, input logic [1:0] en,
                      input logic [1:0] t0, input logic [1:0] t1,
                      input logic [4:0] dst, input logic wen, input logic [1:0] tnew,
                      input logic mdu, input logic mds, input logic fl, input logic rst,
                      input bit chk, input string nm,
                      input logic s, input logic b, input logic [3:0] f, input logic bz);
    exp_t e;
    @(posedge clk);
    #1;
    src_addr_d = {a1, a0}; src_en_d = en; src_tuse_d = {t1, t0};
    dst_addr_d = dst; dst_wen_d = wen; dst_tnew_d = tnew;
    md_use_d = mdu; md_start_e = mds; flush_e = fl; reset = rst;
    if (chk) begin
      e.name = nm; e.stall = s; e.bubble = b; e.fwd = f; e.busy = bz;
      exp_q.push_back(e);
    end
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++)
      step(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "", 0, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    step(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "reset", 0, 0, 4'b0000, 0);

    // 1. ALU back-to-back: add $8 tnew=1, then read $8 tuse=0
    step(0, 0, 2'b00, 0, 0, 8, 1, 1, 0, 0, 0, 0, 1, "alu_issue", 0, 0, 4'b0000, 0);
    step(8, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "alu_stall", 1, 1, 4'b0000, 0);
    step(8, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "alu_fwdM", 0, 0, 4'b0010, 0);
    drain(3);

    // 2. Load-use: lw $9 tnew=2, read $9 on operand 1 with tuse=1
    step(0, 0, 2'b00, 0, 0, 9, 1, 2, 0, 0, 0, 0, 1, "lw_issue", 0, 0, 4'b0000, 0);
    step(0, 9, 2'b10, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, "lw_stall", 1, 1, 4'b0000, 0);
    step(0, 9, 2'b10, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, "lw_nostall", 0, 0, 4'b0000, 0);
    drain(3);

    // 3. Youngest wins: two writers of $5 with tnew=0
    step(0, 0, 2'b00, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, "", 0, 0, 0, 0);
    step(0, 0, 2'b00, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, "", 0, 0, 0, 0);
    step(5, 5, 2'b11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "young_E", 0, 0, 4'b0101, 0);
    step(5, 5, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "young_M", 0, 0, 4'b0010, 0);
    drain(3);

    // 4. Register zero and disabled operand
    step(0, 0, 2'b00, 0, 0, 0, 1, 2, 0, 0, 0, 0, 1, "r0_issue", 0, 0, 4'b0000, 0);
    step(0, 0, 2'b11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "r0_read", 0, 0, 4'b0000, 0);
    drain(3);
    step(0, 0, 2'b00, 0, 0, 7, 1, 2, 0, 0, 0, 0, 0, "", 0, 0, 0, 0);
    step(7, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "dis_read", 0, 0, 4'b0000, 0);
    drain(3);

    // 5. MD busy, single start at t
    step(0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, "md_t0", 1, 1, 4'b0000, 0);
    for (int i = 1; i <= 5; i++)
      step(0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, "md_busy", 1, 1, 4'b0000, 1);
    step(0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, "md_t6", 0, 0, 4'b0000, 0);

    // 5b. Restart at t+2 stretches busy through t+7
    step(0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, "mdr_t0", 1, 1, 4'b0000, 0);
    step(0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, "mdr_t1", 1, 1, 4'b0000, 1);
    step(0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, "mdr_t2", 1, 1, 4'b0000, 1);
    for (int i = 3; i <= 7; i++)
      step(0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, "mdr_busy", 1, 1, 4'b0000, 1);
    step(0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, "mdr_t8", 0, 0, 4'b0000, 0);
    drain(1);

    // 6. Flush drops the writer
    step(0, 0, 2'b00, 0, 0, 10, 1, 1, 0, 0, 1, 0, 1, "flush_issue", 0, 1, 4'b0000, 0);
    step(10, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "flush_read", 0, 0, 4'b0000, 0);
    drain(3);

    // 6b. Reset during a load-use stall
    step(0, 0, 2'b00, 0, 0, 9, 1, 2, 0, 0, 0, 0, 1, "rst_issue", 0, 0, 4'b0000, 0);
    step(9, 9, 2'b11, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1, "rst_stall", 1, 1, 4'b0000, 0);
    step(9, 9, 2'b11, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, "rst_after", 0, 0, 4'b0000, 0);

    // Let the monitor consume everything, bounded.
    begin
      int waited = 0;
      while (exp_q.size() > 0 && waited < 20) begin
        @(posedge clk);
        waited++;
      end
      if (exp_q.size() > 0) begin
        errors++;
        $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
    end
    @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
